// File: rtl/ldpc_pkg.sv
// Shared types and constants for the LDPC per-branch LLR bank.
// Optional drop counter is enabled by defining LDPC_LLR_BANK_DROP_COUNT_EN.
package ldpc_pkg;

    localparam int DROP_CNT_W = 16;

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    function automatic int addr_w_f(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ldpc_llr_ram.sv
// WIDTH x DEPTH simple dual-port RAM: one write port, one read port with a
// registered (1-cycle) read.
module ldpc_llr_ram #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 96,
    parameter int ADDR_W = 7
) (
    input  logic              i_clock,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge i_clock) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_re) begin
            o_rdata <= mem_q[i_raddr];
        end
    end

endmodule

// File: rtl/ldpc_llr_bank.sv
// Per-branch LLR bank: scattered per-RAM loads, then a row-wise drain over a
// valid/ready stream. Define LDPC_LLR_BANK_DROP_COUNT_EN to add o_drop_count.
module ldpc_llr_bank
    import ldpc_pkg::*;
#(
    parameter int WIDTH            = 8,
    parameter int NUM_RAMS         = 24,
    parameter int EXPANSION_FACTOR = 96,
    parameter int ADDR_W           = addr_w_f(EXPANSION_FACTOR)
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic [NUM_RAMS*WIDTH-1:0]  i_data,
    input  logic [NUM_RAMS*ADDR_W-1:0] i_addr,
    input  logic [NUM_RAMS-1:0]        i_valid,
    output logic [NUM_RAMS*WIDTH-1:0]  o_data,
    output logic [ADDR_W-1:0]          o_addr,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic                       o_loading,
    output logic                       o_overflow
`ifdef LDPC_LLR_BANK_DROP_COUNT_EN
    ,
    output logic [DROP_CNT_W-1:0]      o_drop_count
`endif
);

    localparam int                FILL_W   = $clog2(EXPANSION_FACTOR + 1);
    localparam logic [FILL_W-1:0] FULL     = FILL_W'(EXPANSION_FACTOR);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(EXPANSION_FACTOR - 1);

    state_e                      state_q, state_d;
    logic [FILL_W-1:0]           fill_q [NUM_RAMS];
    logic [FILL_W-1:0]           fill_d [NUM_RAMS];
    logic [FILL_W-1:0]           rd_row_q, rd_row_d;
    logic                        rd_vld_q;
    logic [ADDR_W-1:0]           rd_addr_q;
    logic                        re_s, pop_s, last_s, all_full_s;
    logic [NUM_RAMS-1:0]         we_s, drop_s;
    logic [NUM_RAMS*WIDTH-1:0]   ram_rdata_s;
    logic                        head_vld_q, head_vld_d, sk_vld_q, sk_vld_d;
    logic [NUM_RAMS*WIDTH-1:0]   head_data_q, head_data_d, sk_data_q, sk_data_d;
    logic [ADDR_W-1:0]           head_addr_q, head_addr_d, sk_addr_q, sk_addr_d;
    logic                        loading_q, ovf_q;

    for (genvar r = 0; r < NUM_RAMS; r++) begin : g_ram
        ldpc_llr_ram #(
            .WIDTH (WIDTH),
            .DEPTH (EXPANSION_FACTOR),
            .ADDR_W(ADDR_W)
        ) u_ram (
            .i_clock(i_clock),
            .i_we   (we_s[r]),
            .i_waddr(i_addr[r*ADDR_W +: ADDR_W]),
            .i_wdata(i_data[r*WIDTH +: WIDTH]),
            .i_re   (re_s),
            .i_raddr(rd_row_q[ADDR_W-1:0]),
            .o_rdata(ram_rdata_s[r*WIDTH +: WIDTH])
        );
    end

    // Write acceptance, drop detection and fill tracking per RAM lane
    always_comb begin
        we_s       = '0;
        drop_s     = '0;
        all_full_s = 1'b1;
        for (int r = 0; r < NUM_RAMS; r++) begin
            fill_d[r] = fill_q[r];
            if (i_valid[r]) begin
                if ((state_q == ST_LOAD) && (fill_q[r] != FULL) &&
                    (int'(i_addr[r*ADDR_W +: ADDR_W]) < EXPANSION_FACTOR)) begin
                    we_s[r]   = 1'b1;
                    fill_d[r] = fill_q[r] + FILL_W'(1);
                end else begin
                    drop_s[r] = 1'b1;
                end
            end else begin
                we_s[r] = 1'b0;
            end
            if (fill_d[r] != FULL) begin
                all_full_s = 1'b0;
            end else begin
                all_full_s = all_full_s;
            end
            if (last_s) begin
                fill_d[r] = '0;
            end else begin
                fill_d[r] = fill_d[r];
            end
        end
    end

    // Issue a read only when the skid is guaranteed room two edges later
    always_comb begin
        state_d  = state_q;
        rd_row_d = rd_row_q;
        re_s     = 1'b0;
        pop_s    = head_vld_q & i_ready;
        last_s   = (state_q == ST_DRAIN) && pop_s && (head_addr_q == LAST_ROW);
        case (state_q)
            ST_LOAD: begin
                rd_row_d = '0;
                if (all_full_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if ((rd_row_q != FULL) &&
                    ((2'(head_vld_q) + 2'(sk_vld_q) + 2'(rd_vld_q)) <= (2'd1 + 2'(pop_s)))) begin
                    re_s     = 1'b1;
                    rd_row_d = rd_row_q + FILL_W'(1);
                end else begin
                    re_s = 1'b0;
                end
                if (last_s) begin
                    state_d  = ST_LOAD;
                    rd_row_d = '0;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d  = ST_LOAD;
                rd_row_d = '0;
            end
        endcase
    end

    // Two-entry output skid: head drives the stream, spare catches in-flight reads
    always_comb begin
        head_vld_d  = head_vld_q;
        head_data_d = head_data_q;
        head_addr_d = head_addr_q;
        sk_vld_d    = sk_vld_q;
        sk_data_d   = sk_data_q;
        sk_addr_d   = sk_addr_q;
        if (!head_vld_q || pop_s) begin
            if (sk_vld_q) begin
                head_vld_d  = 1'b1;
                head_data_d = sk_data_q;
                head_addr_d = sk_addr_q;
                sk_vld_d    = rd_vld_q;
                sk_data_d   = ram_rdata_s;
                sk_addr_d   = rd_addr_q;
            end else if (rd_vld_q) begin
                head_vld_d  = 1'b1;
                head_data_d = ram_rdata_s;
                head_addr_d = rd_addr_q;
                sk_vld_d    = 1'b0;
            end else begin
                head_vld_d = 1'b0;
            end
        end else if (rd_vld_q) begin
            sk_vld_d  = 1'b1;
            sk_data_d = ram_rdata_s;
            sk_addr_d = rd_addr_q;
        end else begin
            sk_vld_d = sk_vld_q;
        end
    end

    // State, fill, read pipeline, skid and status registers
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q     <= ST_LOAD;
            rd_row_q    <= '0;
            rd_vld_q    <= 1'b0;
            rd_addr_q   <= '0;
            head_vld_q  <= 1'b0;
            head_data_q <= '0;
            head_addr_q <= '0;
            sk_vld_q    <= 1'b0;
            sk_data_q   <= '0;
            sk_addr_q   <= '0;
            loading_q   <= 1'b1;
            ovf_q       <= 1'b0;
            for (int r = 0; r < NUM_RAMS; r++) begin
                fill_q[r] <= '0;
            end
        end else begin
            state_q     <= state_d;
            rd_row_q    <= rd_row_d;
            rd_vld_q    <= re_s;
            rd_addr_q   <= rd_row_q[ADDR_W-1:0];
            head_vld_q  <= head_vld_d;
            head_data_q <= head_data_d;
            head_addr_q <= head_addr_d;
            sk_vld_q    <= sk_vld_d;
            sk_data_q   <= sk_data_d;
            sk_addr_q   <= sk_addr_d;
            loading_q   <= (state_d == ST_LOAD);
            ovf_q       <= ovf_q | (|drop_s);
            for (int r = 0; r < NUM_RAMS; r++) begin
                fill_q[r] <= fill_d[r];
            end
        end
    end

    assign o_data     = head_data_q;
    assign o_addr     = head_addr_q;
    assign o_valid    = head_vld_q;
    assign o_loading  = loading_q;
    assign o_overflow = ovf_q;

`ifdef LDPC_LLR_BANK_DROP_COUNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [DROP_CNT_W:0]   drop_sum_s;

    // Saturating sum of dropped lanes this cycle
    always_comb begin
        drop_sum_s = {1'b0, drop_cnt_q};
        for (int r = 0; r < NUM_RAMS; r++) begin
            drop_sum_s = drop_sum_s + (DROP_CNT_W+1)'(drop_s[r]);
        end
        if (drop_sum_s[DROP_CNT_W]) begin
            drop_cnt_d = '1;
        end else begin
            drop_cnt_d = drop_sum_s[DROP_CNT_W-1:0];
        end
    end

    // Drop counter register
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_ldpc_llr_bank.sv
// Self-checking bench for ldpc_llr_bank (4 RAMs x 8 words) plus a small
// 1-RAM x 6-word instance for the out-of-range address case.
module tb_ldpc_llr_bank;

    localparam int W = 8, NR = 4, EF = 8, AW = 3;

    logic clk;
    logic rst_n;
    logic [NR*W-1:0]  din, dout;
    logic [NR*AW-1:0] ain;
    logic [NR-1:0]    vin;
    logic [AW-1:0]    aout;
    logic rdy, vout, loading, ovf;
    logic [7:0] d2, dout2;
    logic [2:0] a2, aout2;
    logic v2, rdy2, vout2, loading2, ovf2;
`ifdef LDPC_LLR_BANK_DROP_COUNT_EN
    logic [15:0] dc, dc2;
`endif

    ldpc_llr_bank #(.WIDTH(W), .NUM_RAMS(NR), .EXPANSION_FACTOR(EF)) dut (
        .i_clock(clk), .i_reset(rst_n), .i_data(din), .i_addr(ain), .i_valid(vin),
        .o_data(dout), .o_addr(aout), .o_valid(vout), .i_ready(rdy),
        .o_loading(loading), .o_overflow(ovf)
`ifdef LDPC_LLR_BANK_DROP_COUNT_EN
        , .o_drop_count(dc)
`endif
    );

    ldpc_llr_bank #(.WIDTH(8), .NUM_RAMS(1), .EXPANSION_FACTOR(6)) dut2 (
        .i_clock(clk), .i_reset(rst_n), .i_data(d2), .i_addr(a2), .i_valid(v2),
        .o_data(dout2), .o_addr(aout2), .o_valid(vout2), .i_ready(rdy2),
        .o_loading(loading2), .o_overflow(ovf2)
`ifdef LDPC_LLR_BANK_DROP_COUNT_EN
        , .o_drop_count(dc2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0, bad = 0;

    // reference model: memory image, fill counts, expected row stream
    logic [7:0]      m_mem [NR][EF];
    int              m_fill [NR];
    bit              m_load, m_ovf;
    int              m_drops, frames = 0;
    logic [NR*W-1:0] q_data [$];
    int              q_addr [$];
    bit              stall_p;
    logic [NR*W-1:0] stall_d;
    logic [AW-1:0]   stall_a;

    typedef struct {
        logic        rdy;
        logic        exp_valid;
        logic [2:0]  exp_addr;
        logic [31:0] exp_data;
        logic        exp_load;
    } vec_t;
    vec_t tbl [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NR*W-1:0] row_word(input int base, input int a);
        logic [NR*W-1:0] w;
        for (int r = 0; r < NR; r++) w[r*W +: W] = 8'(base + 16*r + a);
        return w;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++) m_fill[r] = 0;
        m_load = 1'b1; m_ovf = 1'b0; m_drops = 0; stall_p = 1'b0;
        q_data.delete(); q_addr.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; vin = '0; rdy = 1'b0; v2 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // drive one cycle, check outputs against the model, advance the model
    task automatic step(input logic [NR-1:0] v, input logic [NR*W-1:0] d,
                        input logic [NR*AW-1:0] a, input logic r);
        bit xfer, popped, full;
        int ad;
        vin = v; din = d; ain = a; rdy = r;
        popped = 1'b0;
        check("loading", loading, m_load);
        check("overflow", ovf, m_ovf);
`ifdef LDPC_LLR_BANK_DROP_COUNT_EN
        check("drop_count", dc, m_drops);
`endif
        if (stall_p) begin
            check("stall_valid", vout, 1'b1);
            check("stall_data", dout, stall_d);
            check("stall_addr", aout, stall_a);
        end
        xfer = vout && r;
        if (xfer) begin
            check("row_pending", 64'(q_data.size() > 0), 64'd1);
            if (q_data.size() > 0) begin
                check("row_data", dout, q_data[0]);
                check("row_addr", aout, q_addr[0]);
                void'(q_data.pop_front());
                void'(q_addr.pop_front());
                popped = 1'b1;
            end
        end
        stall_p = vout && !r; stall_d = dout; stall_a = aout;
        for (int k = 0; k < NR; k++) begin
            if (v[k]) begin
                ad = int'(a[k*AW +: AW]);
                if (m_load && m_fill[k] < EF && ad < EF) begin
                    m_mem[k][ad] = d[k*W +: W];
                    m_fill[k]++;
                end else begin
                    m_ovf = 1'b1;
                    m_drops++;
                end
            end
        end
        if (popped && q_data.size() == 0) begin
            m_load = 1'b1;
            for (int k = 0; k < NR; k++) m_fill[k] = 0;
            frames++;
        end
        full = 1'b1;
        for (int k = 0; k < NR; k++) if (m_fill[k] != EF) full = 1'b0;
        if (m_load && full) begin
            m_load = 1'b0;
            for (int row = 0; row < EF; row++) begin
                logic [NR*W-1:0] w;
                for (int k = 0; k < NR; k++) w[k*W +: W] = m_mem[k][row];
                q_data.push_back(w);
                q_addr.push_back(row);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic fill_lanes(input logic [NR-1:0] lanes, input int base);
        logic [NR*AW-1:0] a;
        for (int row = 0; row < EF; row++) begin
            for (int k = 0; k < NR; k++) a[k*AW +: AW] = 3'(row);
            step(lanes, row_word(base, row), a, 1'b1);
        end
    endtask

    // mode 0: ready high, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic drain(input int mode);
        bit seen, r;
        seen = 1'b0;
        for (int i = 0; i < 200 && (!m_load || q_data.size() > 0); i++) begin
            r = (mode == 0) ? 1'b1 : (mode == 1) ? ((i % 4) == 0 || (i % 4) == 3)
                                                  : ($urandom_range(0, 3) != 0);
            if (seen && r && q_data.size() > 0) check("no_gap", vout, 1'b1);
            seen = seen | vout;
            step('0, '0, '0, r);
        end
        check("drain_done", m_load, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 11; k++) begin
            tbl[k].rdy       = 1'b1;
            tbl[k].exp_valid = (k >= 2 && k <= 9);
            tbl[k].exp_addr  = 3'(k - 2);
            tbl[k].exp_data  = row_word(0, k - 2);
            tbl[k].exp_load  = (k == 10);
        end
        din = '0; ain = '0; vin = '0; rdy = 1'b0;
        d2 = '0; a2 = '0; v2 = 1'b0; rdy2 = 1'b1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        do_reset();
        check("rst_valid", vout, 1'b0);
        check("rst_data", dout, 32'h0);
        check("rst_addr", aout, 3'h0);
        check("rst_loading", loading, 1'b1);
        check("rst_overflow", ovf, 1'b0);

        // fill and full-rate drain with exact cycle timing
        fill_lanes(4'hF, 0);
        for (int k = 0; k < 11; k++) begin
            check("tbl_valid", vout, tbl[k].exp_valid);
            check("tbl_loading", loading, tbl[k].exp_load);
            if (tbl[k].exp_valid) begin
                check("tbl_addr", aout, tbl[k].exp_addr);
                check("tbl_data", dout, tbl[k].exp_data);
            end
            step('0, '0, '0, tbl[k].rdy);
        end

        // backpressure
        fill_lanes(4'hF, 1);
        drain(1);

        // uneven fill
        fill_lanes(4'b0001, 2);
        step('0, '0, '0, 1'b1);
        step('0, '0, '0, 1'b1);
        check("uneven_loading", loading, 1'b1);
        fill_lanes(4'b1110, 3);
        check("uneven_ovf", ovf, 1'b0);
        drain(0);

        // overflow: 9th write to RAM 2, then a write during DRAIN
        fill_lanes(4'b0100, 4);
        step(4'b0100, 32'hEEEE_EEEE, '0, 1'b1);
        fill_lanes(4'b1011, 5);
        step(4'b0001, 32'hDDDD_DDDD, '0, 1'b1);
        drain(0);
        step('0, '0, '0, 1'b1);
        check("ovf_sticky", ovf, 1'b1);
`ifdef LDPC_LLR_BANK_DROP_COUNT_EN
        check("drop_count_ovf", dc, 16'd2);
`endif

        // reset mid-drain after row 4 transfers
        fill_lanes(4'hF, 6);
        for (int i = 0; i < 40 && q_data.size() > 3; i++) step('0, '0, '0, 1'b1);
        do_reset();
        check("middrain_valid", vout, 1'b0);
        check("middrain_loading", loading, 1'b1);
        check("middrain_ovf", ovf, 1'b0);
        fill_lanes(4'hF, 7);
        drain(0);

        // randomized frames
        begin
            int target;
            logic [NR*AW-1:0] a;
            target = frames + 3;
            for (int i = 0; i < 1200 && frames < target; i++) begin
                for (int k = 0; k < NR; k++) a[k*AW +: AW] = 3'($urandom_range(0, EF - 1));
                step(4'($urandom), $urandom, a, $urandom_range(0, 3) != 0);
            end
            check("rand_frames", frames, target);
        end

        // out-of-range address on the 6-deep instance
        v2 = 1'b1; a2 = 3'd7; d2 = 8'hAA;
        @(posedge clk); #1;
        v2 = 1'b0;
        check("oor_ovf", ovf2, 1'b1);
        check("oor_loading", loading2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            v2 = 1'b1; a2 = 3'(i); d2 = 8'(8'h40 + i);
            @(posedge clk); #1;
        end
        v2 = 1'b0;
        @(posedge clk); #1;
        check("oor_no_fill", loading2, 1'b1);
        v2 = 1'b1; a2 = 3'd5; d2 = 8'h45;
        @(posedge clk); #1;
        v2 = 1'b0;
        check("oor_drain", loading2, 1'b0);
        rdy2 = 1'b0;
        for (int i = 0; i < 10 && !vout2; i++) begin
            @(posedge clk); #1;
        end
        check("oor_row0", {vout2, aout2, dout2}, {1'b1, 3'd0, 8'h40});
`ifdef LDPC_LLR_BANK_DROP_COUNT_EN
        check("oor_drop_count", dc2, 16'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
